// File: rtl/ark_pkg.sv
// Shared constants, types and helpers for the AddRoundKey streaming stage.
package ark_pkg;

    localparam int AES_BLK_W       = 128;
    localparam int NUM_KEYS_AES128 = 11;
    localparam int NUM_KEYS_AES192 = 13;
    localparam int NUM_KEYS_AES256 = 15;

    typedef logic [AES_BLK_W-1:0] blk_t;

    // True when a round-key index addresses a populated key slot (no modulo wrap).
    function automatic logic kidx_ok(input int unsigned idx, input int unsigned n);
        return idx < n;
    endfunction

endpackage

// File: rtl/ark_skid_fifo2.sv
// Generic 2-entry valid/ready FIFO. in_ready is a pure decode of the entry count,
// so there is no combinational path from out_ready to in_ready.
module ark_skid_fifo2 #(
    parameter int W = 129
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next-state: write at the tail on push, advance the head on pop, track occupancy.
    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State register; reset empties the buffer and zeroes the visible output word.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/add_round_key_stream.sv
// Streaming AddRoundKey stage: local round-key store, per-beat key select and XOR,
// results delivered through a 2-entry valid/ready buffer.
// Optional feature macro: ARK_KEY_CLEAR_EN adds the key_clr zeroize port.
module add_round_key_stream
    import ark_pkg::*;
#(
    parameter int DATA_W   = AES_BLK_W,
    parameter int NUM_KEYS = NUM_KEYS_AES128,
    parameter int KIDX_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_we,
    input  logic [KIDX_W-1:0] key_widx,
    input  logic [DATA_W-1:0] key_wdata,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_state,
    input  logic [KIDX_W-1:0] in_kidx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
`ifdef ARK_KEY_CLEAR_EN
    ,
    input  logic              key_clr
`endif
);

    logic [DATA_W-1:0] key_q [NUM_KEYS];
    logic [DATA_W-1:0] key_d [NUM_KEYS];
    logic [DATA_W-1:0] key_sel;
    logic              beat_err;

    // Key store update: indexed write (out-of-range index ignored), optional zeroize wins.
    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            key_d[k] = key_q[k];
            if (key_we && (key_widx == KIDX_W'(k))) begin
                key_d[k] = key_wdata;
            end
`ifdef ARK_KEY_CLEAR_EN
            if (key_clr) begin
                key_d[k] = '0;
            end
`endif
        end
    end

    // Key store register; the beat XOR below always sees the value before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                key_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                key_q[k] <= key_d[k];
            end
        end
    end

    // Key select: an out-of-range index matches no slot and so yields an all-zero key.
    always_comb begin
        key_sel = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (in_kidx == KIDX_W'(k)) begin
                key_sel = key_q[k];
            end
        end
        beat_err = !kidx_ok(32'(in_kidx), unsigned'(NUM_KEYS));
    end

    ark_skid_fifo2 #(
        .W (DATA_W + 1)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({beat_err, in_state ^ key_sel}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  ({out_err, out_data})
    );

endmodule

// File: tb/tb_add_round_key_stream.sv
// Self-checking bench for add_round_key_stream: directed scenarios followed by a
// randomized phase, checked against a queue/array reference model.
module tb_add_round_key_stream;

    localparam int NK = 11;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_we;
    logic [3:0]   key_widx;
    logic [127:0] key_wdata;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [3:0]   in_kidx;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_err;
`ifdef ARK_KEY_CLEAR_EN
    logic         key_clr;
`endif

    typedef struct {
        logic         err;
        logic [127:0] data;
    } beat_t;

    beat_t        exp_q [$];
    logic [127:0] mkey [16];
    int           n_pass  = 0;
    int           n_total = 0;

    always #5 clk = ~clk;

    add_round_key_stream dut (
        .clk       (clk),
        .rst       (rst),
        .key_we    (key_we),
        .key_widx  (key_widx),
        .key_wdata (key_wdata),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_kidx   (in_kidx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
`ifdef ARK_KEY_CLEAR_EN
        ,
        .key_clr   (key_clr)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: check outputs against the model, predict the edge, advance.
    task automatic step(input string tag);
        beat_t b;
        bit    push;
        bit    pop;
        int    idx;
        chk({tag, ":out_valid"}, 128'(out_valid), 128'(exp_q.size() != 0));
        chk({tag, ":in_ready"}, 128'(in_ready), 128'(exp_q.size() < 2));
        if (exp_q.size() != 0) begin
            chk({tag, ":out_data"}, out_data, exp_q[0].data);
            chk({tag, ":out_err"}, 128'(out_err), 128'(exp_q[0].err));
        end
        idx    = int'(in_kidx);
        b.err  = (idx >= NK);
        b.data = b.err ? in_state : (in_state ^ mkey[idx]);
        push   = in_valid && (exp_q.size() < 2);
        pop    = out_ready && (exp_q.size() > 0);
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            for (int k = 0; k < 16; k++) mkey[k] = '0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (push) exp_q.push_back(b);
            if (key_we && (int'(key_widx) < NK)) mkey[int'(key_widx)] = key_wdata;
`ifdef ARK_KEY_CLEAR_EN
            if (key_clr) for (int k = 0; k < 16; k++) mkey[k] = '0;
`endif
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; key_we = 1'b0; key_widx = '0; key_wdata = '0;
        in_valid = 1'b0; in_state = '0; in_kidx = '0; out_ready = 1'b1;
`ifdef ARK_KEY_CLEAR_EN
        key_clr = 1'b0;
`endif
        for (int k = 0; k < 16; k++) mkey[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: reset state, key store reads zero
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_out_err", 128'(out_err), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        in_valid = 1'b1; in_state = {16{8'hA5}}; in_kidx = 4'd0;
        step("t1_push");
        in_valid = 1'b0;
        chk("t1_passthru", out_data, {16{8'hA5}});
        step("t1_drain");

        // 2: FIPS-197 round 0 AddRoundKey
        key_we = 1'b1; key_widx = 4'd0; key_wdata = 128'h000102030405060708090a0b0c0d0e0f;
        step("t2_kwr");
        key_we = 1'b0;
        in_valid = 1'b1; in_state = 128'h00112233445566778899aabbccddeeff; in_kidx = 4'd0;
        step("t2_push");
        in_valid = 1'b0;
        chk("t2_fips", out_data, 128'h00102030405060708090a0b0c0d0e0f0);
        chk("t2_err", 128'(out_err), 128'(0));
        step("t2_drain");

        // 3: back-pressure with three beats offered
        out_ready = 1'b0; in_valid = 1'b1; in_kidx = 4'd0;
        in_state = 128'h1; step("t3_a");
        in_state = 128'h2; step("t3_b");
        in_state = 128'h3; step("t3_stall");
        chk("t3_full", 128'(in_ready), 128'(0));
        step("t3_stall2");
        out_ready = 1'b1; step("t3_release");
        in_valid = 1'b0;
        repeat (4) step("t3_drain");

        // 4: same-cycle key write vs beat on the same index
        key_we = 1'b1; key_widx = 4'd3; key_wdata = 128'h3333;
        in_valid = 1'b1; in_kidx = 4'd3; in_state = 128'hF0F0;
        step("t4_same");
        key_we = 1'b0; in_state = 128'h0F0F;
        chk("t4_oldkey", out_data, 128'hF0F0);
        step("t4_new");
        in_valid = 1'b0;
        chk("t4_newkey", out_data, 128'h0F0F ^ 128'h3333);
        step("t4_drain");

        // 5: out-of-range read and write indices
        in_valid = 1'b1; in_kidx = 4'd12; in_state = 128'hCAFE;
        key_we = 1'b1; key_widx = 4'd15; key_wdata = '1;
        step("t5_oor");
        key_we = 1'b0; in_kidx = 4'd11; in_state = 128'hBEEF;
        chk("t5_err", 128'(out_err), 128'(1));
        chk("t5_data", out_data, 128'hCAFE);
        step("t5_edge");
        in_kidx = 4'd10; in_state = 128'h5;
        chk("t5_err11", 128'(out_err), 128'(1));
        step("t5_k10");
        in_valid = 1'b0;
        chk("t5_k10_ok", 128'(out_err), 128'(0));
        step("t5_drain");

`ifdef ARK_KEY_CLEAR_EN
        // 6b: zeroize keys with buffered data intact
        out_ready = 1'b0; in_valid = 1'b1; in_kidx = 4'd3; in_state = 128'h77;
        step("t6c_a"); step("t6c_b");
        in_valid = 1'b0; key_clr = 1'b1; step("t6c_clr");
        key_clr = 1'b0; out_ready = 1'b1;
        repeat (3) step("t6c_drain");
        in_valid = 1'b1; in_kidx = 4'd0; in_state = 128'h99; step("t6c_zero");
        in_valid = 1'b0;
        chk("t6c_zeroed", out_data, 128'h99);
        step("t6c_end");
`endif

        // 6: reset with two beats buffered
        out_ready = 1'b0; in_valid = 1'b1; in_kidx = 4'd0; in_state = 128'hAB;
        step("t6_a"); step("t6_b");
        in_valid = 1'b0; rst = 1'b1; step("t6_rst");
        rst = 1'b0;
        chk("t6_empty", 128'(out_valid), 128'(0));
        chk("t6_zero", out_data, 128'(0));
        out_ready = 1'b1;
        step("t6_idle");

        // random phase
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_state  = rnd128();
            in_kidx   = 4'($urandom_range(0, 15));
            key_we    = ($urandom_range(0, 4) == 0);
            key_widx  = 4'($urandom_range(0, 15));
            key_wdata = rnd128();
            rst       = ($urandom_range(0, 99) == 0);
`ifdef ARK_KEY_CLEAR_EN
            key_clr   = ($urandom_range(0, 49) == 0);
`endif
            step("rand");
        end
        rst = 1'b0; key_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
`ifdef ARK_KEY_CLEAR_EN
        key_clr = 1'b0;
`endif
        repeat (3) step("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
